// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  // Stream byte order: first byte of a word lands in the most significant lane.
  localparam bit MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_LOAD = 3'd1,
    S_CHK  = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_ready;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic            cpu_run;
  logic            busy;
  logic            err;
  logic [ADDR_W:0] words_loaded;

  // Loader side.
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, err, words_loaded
  );

  // Stream source / system side.
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, err, words_loaded
  );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs accepted stream bytes into 32-bit words; pulses word_valid on the 4th byte.
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  input  logic              rx_ready_i,
  output logic [WORD_W-1:0] word_c_o,
  output logic              word_valid_c_o
);

  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] packed_c;
  logic              xfer_c;

  // Handshake, byte counter and shift register next-state.
  always_comb begin
    xfer_c   = rx_valid_i && rx_ready_i;
    packed_c = MSB_FIRST ? {shift_q[WORD_W-BYTE_W-1:0], rx_data_i}
                         : {rx_data_i, shift_q[WORD_W-1:BYTE_W]};
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    if (xfer_c) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = packed_c;
    end
  end

  assign word_c_o       = packed_c;
  assign word_valid_c_o = xfer_c && (cnt_q == 2'd3);

  // Counter and partial-word storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: header word count, payload words written to instruction
// memory, then CPU release. Define IMEM_LOADER_CHECKSUM_EN to require a
// trailing 32-bit sum of the payload words before release.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)(
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [32:0] MAX_N = 33'(1) << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e AFTER_LOAD = S_CHK;
`else
  localparam state_e AFTER_LOAD = S_RUN;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              rx_ready_q, rx_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_run_q, cpu_run_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] word_c;
  logic              word_valid_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
`endif

  byte_assembler u_asm (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data_i      (bus.rx_data),
    .rx_valid_i     (bus.rx_valid),
    .rx_ready_i     (rx_ready_q),
    .word_c_o       (word_c),
    .word_valid_c_o (word_valid_c)
  );

  // Load sequencing and registered output next-state.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    words_d     = words_q;
    rx_ready_d  = rx_ready_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    case (state_q)
      S_HDR: begin
        rx_ready_d = 1'b1;
        if (word_valid_c) begin
          if (word_c == 32'd0) begin
            state_d = AFTER_LOAD;
          end else if ({1'b0, word_c} > MAX_N) begin
            state_d = S_ERR;
          end else begin
            state_d = S_LOAD;
            n_d     = CNT_W'(word_c);
          end
        end
      end
      S_LOAD: begin
        if (word_valid_c) begin
          // Write cycle: stall the stream for one cycle while the word lands.
          mem_we_d    = 1'b1;
          mem_addr_d  = BASE_ADDR + (32'(words_q) << 2);
          mem_wdata_d = word_c;
          rx_ready_d  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d       = sum_q + word_c;
`endif
        end else if (mem_we_q) begin
          words_d    = words_q + CNT_W'(1);
          rx_ready_d = 1'b1;
          if (words_d == n_q) begin
            state_d = AFTER_LOAD;
          end
        end
      end
      S_CHK: begin
        rx_ready_d = 1'b1;
        if (word_valid_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = (word_c == sum_q) ? S_RUN : S_ERR;
`else
          state_d = S_ERR;
`endif
        end
      end
      S_RUN, S_ERR: begin
        rx_ready_d = 1'b0;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase

    if (state_d == S_RUN || state_d == S_ERR) begin
      rx_ready_d = 1'b0;
    end
    cpu_run_d = (state_d == S_RUN);
    err_d     = (state_d == S_ERR);
    busy_d    = !(cpu_run_d || err_d);
  end

  // State and output registers; reset discards any partial load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HDR;
      n_q         <= '0;
      words_q     <= '0;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      words_q     <= words_d;
      rx_ready_q  <= rx_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_run_q   <= cpu_run_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign bus.rx_ready     = rx_ready_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.cpu_run      = cpu_run_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;
  assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued by stimulus,
// popped and compared by a monitor whenever mem_we is seen.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 8;
  localparam logic [31:0] BASE   = 32'h0000_0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  wr_t exp_q[$];
  int we_cyc[$];
  wr_t mon_e;
  logic [31:0] img [0:7];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && bus.mem_we === 1'b1) begin
      we_cyc.push_back(cycle);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", bus.mem_addr, mon_e.addr);
        check("wr_data", bus.mem_wdata, mon_e.data);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      n = int'($urandom_range(0, 2));
      if (n > 0) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'hEE;
        repeat (n) @(negedge clk);
      end
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: rx_ready stuck at %b, expected 1", bus.rx_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = w[31-8*i -: 8];
      send_byte(b, gaps);
    end
  endtask

  task automatic load_image(input logic [31:0] hdr, input int n, input bit gaps,
                            input logic [31:0] chk_delta);
    logic [31:0] sum;
    wr_t e;
    sum = 32'd0;
    send_word(hdr, gaps);
    for (int i = 0; i < n; i++) begin
      e.addr = BASE + 32'(i) * 32'd4;
      e.data = img[i];
      exp_q.push_back(e);
      sum = sum + img[i];
      send_word(img[i], gaps);
    end
    if (CK) send_word(sum + chk_delta, gaps);
    bus.rx_valid = 1'b0;
  endtask

  // Terminal-state checks; then extra stream bytes must never be accepted.
  task automatic expect_end(input bit run, input int words, input bit extra_cycle);
    int acc;
    if (extra_cycle) @(negedge clk);
    check("cpu_run", 32'(bus.cpu_run), 32'(run));
    check("err", 32'(bus.err), 32'(!run));
    check("busy", 32'(bus.busy), 32'd0);
    check("words_loaded", 32'(bus.words_loaded), 32'(words));
    acc = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    repeat (6) begin
      if (bus.rx_ready !== 1'b0) acc++;
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    check("ignored_bytes", 32'(acc), 32'd0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check("cpu_run_hold", 32'(bus.cpu_run), 32'(run));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, BASE);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_cpu_run", 32'(bus.cpu_run), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_words", 32'(bus.words_loaded), 32'd0);
    bus.rx_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rx_ready_after_reset", 32'(bus.rx_ready), 32'd1);
    we_cyc.delete();
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    apply_reset();

    // Two-word continuous load.
    img[0] = 32'h2008_0005;
    img[1] = 32'hAC09_0000;
    load_image(32'd2, 2, 1'b0, 32'd0);
    expect_end(1'b1, 2, !CK);
    check("we_count", 32'(we_cyc.size()), 32'd2);
    if (we_cyc.size() == 2) check("we_spacing", 32'(we_cyc[1] - we_cyc[0]), 32'd5);

    // Empty image.
    apply_reset();
    load_image(32'd0, 0, 1'b0, 32'd0);
    expect_end(1'b1, 0, 1'b0);
    check("n0_no_writes", 32'(we_cyc.size()), 32'd0);

    // Oversized image: header only, then terminal error.
    apply_reset();
    send_word(32'h0000_0101, 1'b0);
    bus.rx_valid = 1'b0;
    expect_end(1'b0, 0, 1'b0);
    check("oversize_no_writes", 32'(we_cyc.size()), 32'd0);

    // Three words with random rx_valid gaps.
    apply_reset();
    img[0] = 32'hDEAD_BEEF;
    img[1] = 32'h0123_4567;
    img[2] = 32'h89AB_CDEF;
    load_image(32'd3, 3, 1'b1, 32'd0);
    expect_end(1'b1, 3, !CK);

    // Reset after six bytes, then a fresh load from BASE.
    apply_reset();
    send_word(32'd3, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    bus.rx_valid = 1'b0;
    apply_reset();
    load_image(32'd3, 3, 1'b0, 32'd0);
    expect_end(1'b1, 3, !CK);

    // Reset landing inside a write cycle drops mem_we immediately.
    apply_reset();
    img[0] = 32'hCAFE_F00D;
    exp_q.push_back({BASE, 32'hCAFE_F00D});
    send_word(32'd2, 1'b0);
    send_word(32'hCAFE_F00D, 1'b0);
    check("we_before_reset", 32'(bus.mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("we_async_drop", 32'(bus.mem_we), 32'd0);
    check("busy_async", 32'(bus.busy), 32'd1);
    apply_reset();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum trailer: 1 + 0xFFFFFFFF wraps to 0.
    img[0] = 32'h0000_0001;
    img[1] = 32'hFFFF_FFFF;
    load_image(32'd2, 2, 1'b0, 32'd0);
    expect_end(1'b1, 2, 1'b0);
    apply_reset();
    load_image(32'd2, 2, 1'b0, 32'd1);
    expect_end(1'b0, 2, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
